// File: rtl/product_dispenser_if.sv
// Bundle of the dispenser's purchase, sensor and status signals.
// master = the upstream controller/environment, slave = the dispenser.
interface product_dispenser_if;
    logic [1:0] P;
    logic       confirm;
    logic       drop_sensor;
    logic       clear_error;
    logic [2:0] motor;
    logic       busy;
    logic       done;
    logic [1:0] done_code;
    logic       dropped;
    logic       error;

    modport master (
        output P, confirm, drop_sensor, clear_error,
        input  motor, busy, done, done_code, dropped, error
    );

    modport slave (
        input  P, confirm, drop_sensor, clear_error,
        output motor, busy, done, done_code, dropped, error
    );
endinterface

// File: rtl/product_dispenser.sv
// Product dispenser: queues confirmed purchases, runs one slot motor per
// purchase for a fixed time, waits for the drop sensor, reports completion
// and latches a fault when a product never drops.
module product_dispenser #(
    parameter int MOTOR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                reset,
    product_dispenser_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMAX  = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0] RUN_LAST  = TMR_W'(MOTOR_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_DROP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               seen_q, seen_d;
    logic [1:0]         cur_code_q, cur_code_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         motor_q, motor_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         done_code_q, done_code_d;
    logic               dropped_q, dropped_d;
    logic               error_q, error_d;

    logic [1:0]         mem [FIFO_DEPTH];
    logic               req, push, pop, flush;
    logic [2:0]         code_onehot;

    // A request is a confirm carrying a real slot; it is accepted only if there is room and no fault
    assign req  = bus.confirm && (bus.P != 2'd0);
    assign push = req && (count_q < CNT_FULL) && (state_q != S_FAULT);

    // Slot k drives motor bit k-1
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_onehot
            assign code_onehot[gi] = (cur_code_d == 2'(gi + 1));
        end
    endgenerate

    // Queue storage: written on accepted pushes, no reset needed since count guards reads
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= bus.P;
        end
    end

    // Sequencer next-state: pop, run motor, wait for the drop, complete or fault
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        seen_d     = seen_q;
        cur_code_d = cur_code_q;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    cur_code_d = mem[rd_ptr_q];
                    tmr_d      = '0;
                    seen_d     = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.drop_sensor) begin
                    seen_d = 1'b1;
                end
                if (tmr_q >= RUN_LAST) begin
                    tmr_d   = '0;
                    state_d = S_WAIT_DROP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAIT_DROP: begin
                if (seen_q || bus.drop_sensor) begin
                    state_d = S_DONE;
                end else if (tmr_q >= WAIT_LAST) begin
                    // Product never dropped: discard everything still queued
                    tmr_d   = TMR_W'(TIMEOUT_CYCLES);
                    flush   = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DONE: begin
                seen_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (bus.clear_error) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Queue pointer/occupancy update; fullness is judged on the pre-edge count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Output next-values, aligned with the state they describe
    always_comb begin
        motor_d     = (state_d == S_RUN) ? code_onehot : 3'b000;
        busy_d      = (state_d != S_IDLE) || (count_d != '0);
        done_d      = (state_d == S_DONE);
        done_code_d = (state_d == S_DONE) ? cur_code_q : 2'd0;
        dropped_d   = req && !push;
        error_d     = (state_d == S_FAULT);
    end

    // State, queue and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            seen_q      <= 1'b0;
            cur_code_q  <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            motor_q     <= 3'b000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_code_q <= 2'd0;
            dropped_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            seen_q      <= seen_d;
            cur_code_q  <= cur_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            motor_q     <= motor_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_code_q <= done_code_d;
            dropped_q   <= dropped_d;
            error_q     <= error_d;
        end
    end

    assign bus.motor     = motor_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_code = done_code_q;
    assign bus.dropped   = dropped_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_product_dispenser.sv
// Testbench for product_dispenser: directed scenarios plus random traffic,
// checked by a purchase-lifecycle reference model and an event scoreboard.
module tb_product_dispenser;
    localparam int M = 8;
    localparam int T = 32;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    product_dispenser_if bus();

    product_dispenser #(
        .MOTOR_CYCLES  (M),
        .TIMEOUT_CYCLES(T),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int edge_n;
        int code;
    } ev_t;

    // Reference model: a purchase is popped at edge p, the motor spins over
    // edges p+1..p+M, the drop window covers edges p+M+1..p+M+T.
    int  cyc = 0;
    int  mq[$];
    bit  m_active = 0;
    bit  m_fault  = 0;
    bit  m_seen   = 0;
    int  m_pop_edge = 0;
    int  m_code     = 0;
    int  m_ready    = 0;
    bit  busy_exp   = 0;

    ev_t ev_done[$];
    ev_t ev_drop[$];
    ev_t ev_motor[$];
    ev_t ev_erise[$];
    ev_t ev_efall[$];

    // Monitor-side state
    int  mot_exp  = 0;
    int  mot_left = 0;
    bit  err_exp  = 0;
    int  n_done_obs = 0;
    int  n_drop_obs = 0;
    int  obs_codes[$];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int  pre;
        int  a;
        bit  req;
        bit  ok;
        bit  fault_pre;
        bit  done_now;
        bit  fault_now;
        pre       = mq.size();
        fault_pre = m_fault;
        done_now  = 0;
        fault_now = 0;
        req = bus.confirm && (bus.P != 2'd0);
        ok  = req && (pre < D) && !fault_pre;
        if (req && !ok) ev_drop.push_back(ev_t'{cyc, 0});
        if (m_fault) begin
            if (bus.clear_error) begin
                m_fault = 0;
                m_ready = cyc + 1;
                ev_efall.push_back(ev_t'{cyc, 0});
            end
        end else if (m_active) begin
            a = cyc - m_pop_edge;
            if (a <= M) begin
                if (bus.drop_sensor) m_seen = 1;
            end else if (m_seen || bus.drop_sensor) begin
                done_now = 1;
                m_active = 0;
                m_ready  = cyc + 2;
                ev_done.push_back(ev_t'{cyc, m_code});
            end else if (a == M + T) begin
                fault_now = 1;
                m_active  = 0;
                m_fault   = 1;
                ev_erise.push_back(ev_t'{cyc, 0});
            end
        end else if (pre > 0 && cyc >= m_ready) begin
            m_code     = mq.pop_front();
            m_active   = 1;
            m_pop_edge = cyc;
            m_seen     = 0;
            ev_motor.push_back(ev_t'{cyc, m_code});
        end
        if (ok) mq.push_back(int'(bus.P));
        if (fault_now) mq.delete();
        busy_exp = m_fault || m_active || done_now || (mq.size() > 0);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n) model_step();
    end

    task automatic monitor_step();
        ev_t e;
        if (ev_done.size() > 0 && ev_done[0].edge_n == cyc) begin
            e = ev_done.pop_front();
            check("done_pulse", int'(bus.done), 1);
            check("done_code", int'(bus.done_code), e.code);
        end else begin
            check("done_pulse", int'(bus.done), 0);
            check("done_code_idle", int'(bus.done_code), 0);
        end
        if (bus.done) begin
            n_done_obs++;
            obs_codes.push_back(int'(bus.done_code));
        end
        if (ev_drop.size() > 0 && ev_drop[0].edge_n == cyc) begin
            e = ev_drop.pop_front();
            check("dropped_pulse", int'(bus.dropped), 1);
        end else begin
            check("dropped_pulse", int'(bus.dropped), 0);
        end
        if (bus.dropped) n_drop_obs++;
        if (ev_motor.size() > 0 && ev_motor[0].edge_n == cyc) begin
            e = ev_motor.pop_front();
            mot_exp  = 1 << (e.code - 1);
            mot_left = M;
        end
        if (mot_left > 0) begin
            check("motor_on", int'(bus.motor), mot_exp);
            mot_left--;
        end else begin
            check("motor_off", int'(bus.motor), 0);
        end
        if (ev_erise.size() > 0 && ev_erise[0].edge_n == cyc) begin
            e = ev_erise.pop_front();
            err_exp = 1;
        end
        if (ev_efall.size() > 0 && ev_efall[0].edge_n == cyc) begin
            e = ev_efall.pop_front();
            err_exp = 0;
        end
        check("error", int'(bus.error), int'(err_exp));
        check("busy", int'(bus.busy), int'(busy_exp));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mot_left = 0;
            err_exp  = 0;
        end else begin
            monitor_step();
        end
    end

    task automatic idle_inputs();
        bus.confirm     = 1'b0;
        bus.P           = 2'd0;
        bus.drop_sensor = 1'b0;
        bus.clear_error = 1'b0;
    endtask

    task automatic step(input bit c, input int p, input bit d, input bit clr);
        bus.confirm     = c;
        bus.P           = 2'(p);
        bus.drop_sensor = d;
        bus.clear_error = clr;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Assert reset now, check outputs clear at once, then release between edges
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_motor", int'(bus.motor), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_done_code", int'(bus.done_code), 0);
        check("rst_dropped", int'(bus.dropped), 0);
        check("rst_error", int'(bus.error), 0);
        mq.delete();
        m_active = 0;
        m_fault  = 0;
        m_seen   = 0;
        m_ready  = 0;
        busy_exp = 0;
        ev_done.delete();
        ev_drop.delete();
        ev_motor.delete();
        ev_erise.delete();
        ev_efall.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int d0;
        int s0;
        idle_inputs();
        #1;
        do_reset();

        // Single purchase, drop three cycles after the motor stops
        d0 = n_done_obs;
        s0 = obs_codes.size();
        step(1, 2, 0, 0);
        repeat (M + 3) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        check("single_done_count", n_done_obs - d0, 1);
        if (obs_codes.size() > s0) check("single_code", obs_codes[s0], 2);
        check("single_busy_after", int'(bus.busy), 0);

        // Three queued purchases, drop held high
        d0 = n_done_obs;
        s0 = obs_codes.size();
        step(1, 1, 1, 0);
        step(1, 3, 1, 0);
        step(1, 2, 1, 0);
        repeat (3 * (M + 3) + 10) step(0, 0, 1, 0);
        check("queue_done_count", n_done_obs - d0, 3);
        if (obs_codes.size() >= s0 + 3) begin
            check("queue_code0", obs_codes[s0], 1);
            check("queue_code1", obs_codes[s0 + 1], 3);
            check("queue_code2", obs_codes[s0 + 2], 2);
        end

        // Overflow: one in service, five more confirms, then a P=0 confirm
        d0 = n_done_obs;
        s0 = n_drop_obs;
        step(1, 1, 1, 0);
        repeat (2) step(0, 0, 1, 0);
        repeat (5) step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        repeat (6 * (M + 3) + 10) step(0, 0, 1, 0);
        check("ovf_done_count", n_done_obs - d0, 5);
        check("ovf_drop_count", n_drop_obs - s0, 1);

        // Timeout into fault, rejected confirm, then clear
        s0 = n_drop_obs;
        step(1, 3, 0, 0);
        repeat (M + T + 4) step(0, 0, 0, 0);
        check("to_error", int'(bus.error), 1);
        step(1, 2, 0, 0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        check("to_drop_count", n_drop_obs - s0, 1);
        check("to_error_cleared", int'(bus.error), 0);
        check("to_busy_cleared", int'(bus.busy), 0);

        // Reset during the fourth motor cycle with two purchases queued
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        d0 = n_done_obs;
        @(negedge clk);
        #1;
        do_reset();
        repeat (M + 5) step(0, 0, 1, 0);
        check("rst_no_done", n_done_obs - d0, 0);
        s0 = obs_codes.size();
        step(1, 3, 1, 0);
        repeat (M + 5) step(0, 0, 1, 0);
        if (obs_codes.size() > s0) check("after_rst_code", obs_codes[s0], 3);
        check("after_rst_done_count", n_done_obs - d0, 1);

        // Ten sequential purchases to wrap the queue pointers
        s0 = obs_codes.size();
        for (int k = 0; k < 10; k++) begin
            step(1, (k % 3) + 1, 1, 0);
            repeat (M + 5) step(0, 0, 1, 0);
        end
        check("wrap_count", obs_codes.size() - s0, 10);
        if (obs_codes.size() >= s0 + 10) begin
            for (int k = 0; k < 10; k++) check("wrap_code", obs_codes[s0 + k], (k % 3) + 1);
        end

        // Random traffic: frequent drops first, then sparse drops to provoke faults
        for (int i = 0; i < 1600; i++) begin
            int dp;
            dp = (i < 800) ? 3 : 60;
            if ($urandom_range(0, 399) == 0) begin
                @(negedge clk);
                #1;
                do_reset();
            end
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, dp) == 0, $urandom_range(0, 7) == 0);
        end

        // Drain: keep the chute reporting drops and clear any fault
        repeat (M + T + 40) step(0, 0, 1, 1);
        check("final_busy", int'(bus.busy), 0);
        check("final_error", int'(bus.error), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
